door_sequencer: RTL and testbench

- Parametrised door controller for one elevator car. It generalises the single-period door toggle into a four-phase sequence: CLOSED, OPENING, OPEN, CLOSING.
- Each phase has its own programmable duration. Weight-limit and obstruction interlocks hold or reopen the door.
- A reopen counter triggers nudge mode after repeated obstructions.
- Sits between the car movement controller (open_req, door_closed) and the door motor drivers (motor_open, motor_close).

---
 rtl/door_sequencer.sv | 110 +++++++++++
 tb/tb_door_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/door_sequencer.sv
// Four-phase elevator door controller (CLOSED/OPENING/OPEN/CLOSING) with programmable
// phase durations, weight and obstruction interlocks, and nudge mode after repeated reopens.
module door_sequencer #(
  parameter int CNT_W      = 32,
  parameter int OPEN_TIME  = 2,
  parameter int HOLD_TIME  = 4,
  parameter int CLOSE_TIME = 2,
  parameter int MAX_REOPEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       open_req,
  input  logic       weight_limit_exceeded,
  input  logic       obstruction,
  output logic [1:0] state,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_closed,
  output logic       nudge,
  output logic       door_evt
);

  localparam int RW = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_e;

  door_state_e       cur, nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RW-1:0]     reopen_cnt, reopen_cnt_nxt;
  logic              nudge_nxt;
  logic              hold, obs_live, reopen;

  always_comb begin
    nxt            = cur;
    cnt_nxt        = cnt + CNT_W'(1);
    reopen_cnt_nxt = reopen_cnt;
    nudge_nxt      = nudge;
    hold           = weight_limit_exceeded | obstruction | open_req;
    // In nudge mode the light curtain no longer counts as a reason to reopen.
    obs_live       = obstruction & ~nudge;
    reopen         = weight_limit_exceeded | open_req | obs_live;
    case (cur)
      CLOSED: begin
        cnt_nxt = '0;
        if (open_req) nxt = OPENING;
      end
      OPENING: begin
        if (cnt == CNT_W'(OPEN_TIME - 1)) begin
          nxt     = OPEN;
          cnt_nxt = '0;
        end
      end
      OPEN: begin
        if (hold) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(HOLD_TIME - 1)) begin
          nxt     = CLOSING;
          cnt_nxt = '0;
          if (MAX_REOPEN == 0) nudge_nxt = 1'b1;
        end
      end
      CLOSING: begin
        if (reopen) begin
          nxt     = OPENING;
          cnt_nxt = '0;
          if (obs_live && (reopen_cnt != RW'(MAX_REOPEN))) begin
            reopen_cnt_nxt = reopen_cnt + RW'(1);
            if (reopen_cnt + RW'(1) == RW'(MAX_REOPEN)) nudge_nxt = 1'b1;
          end
        end else if (cnt == CNT_W'(CLOSE_TIME - 1)) begin
          nxt            = CLOSED;
          cnt_nxt        = '0;
          reopen_cnt_nxt = '0;
          nudge_nxt      = 1'b0;
        end
      end
      default: begin
        nxt     = CLOSED;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= CLOSED;
      cnt        <= '0;
      reopen_cnt <= '0;
      nudge      <= 1'b0;
      door_evt   <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      reopen_cnt <= reopen_cnt_nxt;
      nudge      <= nudge_nxt;
      door_evt   <= (nxt != cur);
    end
  end

  assign state       = cur;
  assign motor_open  = (cur == OPENING);
  assign motor_close = (cur == CLOSING);
  assign door_closed = (cur == CLOSED);

endmodule

// File: tb/tb_door_sequencer.sv
// Scoreboard bench for door_sequencer: default build plus a short-timing MAX_REOPEN=0 build,
// both driven by shared stimulus and compared against a countdown-based reference model.
module tb_door_sequencer;

  logic clk;
  logic rst_n;
  logic open_req;
  logic weight_limit_exceeded;
  logic obstruction;

  logic [1:0] state_a, state_b;
  logic mo_a, mc_a, dc_a, nudge_a, evt_a;
  logic mo_b, mc_b, dc_b, nudge_b, evt_b;

  int checks = 0;
  int errors = 0;

  // Expected {state, motor_open, motor_close, door_closed, nudge, door_evt} per cycle.
  logic [6:0] exp_q[$];
  logic [6:0] exp_q_b[$];

  // Reference model state: phase, cycles remaining in phase, reopens used, nudge flag.
  int ph[2];
  int rem[2];
  int reo[2];
  bit nud[2];
  bit evt[2];
  int p_ot[2] = '{2, 1};
  int p_ht[2] = '{4, 1};
  int p_ct[2] = '{2, 5};
  int p_mr[2] = '{3, 0};

  door_sequencer dut (
    .clk(clk), .rst_n(rst_n), .open_req(open_req),
    .weight_limit_exceeded(weight_limit_exceeded), .obstruction(obstruction),
    .state(state_a), .motor_open(mo_a), .motor_close(mc_a), .door_closed(dc_a),
    .nudge(nudge_a), .door_evt(evt_a)
  );

  door_sequencer #(
    .CNT_W(8), .OPEN_TIME(1), .HOLD_TIME(1), .CLOSE_TIME(5), .MAX_REOPEN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .open_req(open_req),
    .weight_limit_exceeded(weight_limit_exceeded), .obstruction(obstruction),
    .state(state_b), .motor_open(mo_b), .motor_close(mc_b), .door_closed(dc_b),
    .nudge(nudge_b), .door_evt(evt_b)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n = 1'b0;
    open_req = 1'b0;
    weight_limit_exceeded = 1'b0;
    obstruction = 1'b0;
  end

  // Reference model: advance one clock edge for configuration i.
  task automatic model_step(input int i, input bit r, input bit o, input bit w, input bit b);
    int prev;
    bit rq;
    logic [6:0] e;
    prev = ph[i];
    if (!r) begin
      ph[i] = 0; rem[i] = 0; reo[i] = 0; nud[i] = 0;
      evt[i] = 0;
    end else begin
      case (ph[i])
        0: if (o) begin ph[i] = 1; rem[i] = p_ot[i]; end
        1: begin
          rem[i]--;
          if (rem[i] == 0) begin ph[i] = 2; rem[i] = p_ht[i]; end
        end
        2: begin
          if (o || w || b) rem[i] = p_ht[i];
          else rem[i]--;
          if (rem[i] == 0) begin
            ph[i] = 3; rem[i] = p_ct[i];
            if (p_mr[i] == 0) nud[i] = 1;
          end
        end
        default: begin
          rq = w || o || (b && !nud[i]);
          if (rq) begin
            if (b && !nud[i] && reo[i] < p_mr[i]) begin
              reo[i]++;
              if (reo[i] == p_mr[i]) nud[i] = 1;
            end
            ph[i] = 1; rem[i] = p_ot[i];
          end else begin
            rem[i]--;
            if (rem[i] == 0) begin ph[i] = 0; reo[i] = 0; nud[i] = 0; end
          end
        end
      endcase
      evt[i] = (ph[i] != prev);
    end
    e = {2'(ph[i]), ph[i] == 1, ph[i] == 3, ph[i] == 0, nud[i], evt[i]};
    if (i == 0) exp_q.push_back(e);
    else exp_q_b.push_back(e);
  endtask

  // Driver: apply inputs for the next rising edge and log what both builds must produce.
  task automatic step(input bit r, input bit o, input bit w, input bit b);
    @(negedge clk);
    rst_n = r;
    open_req = o;
    weight_limit_exceeded = w;
    obstruction = b;
    model_step(0, r, o, w, b);
    model_step(1, r, o, w, b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0);
  endtask

  // Idle until the default-build model sits in phase p (and, if r>=0, has r cycles left).
  task automatic idle_until(input int p, input int r);
    for (int n = 0; n < 60; n++) begin
      if (ph[0] == p && (r < 0 || rem[0] == r)) return;
      step(1, 0, 0, 0);
    end
    checks++;
    errors++;
    $display("FAIL wait_phase: phase %0d not reached within 60 cycles (model phase %0d)", p, ph[0]);
  endtask

  task automatic obstruct_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      idle_until(3, -1);
      step(1, 0, 0, 1);
    end
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [6:0] e;
    logic [6:0] act;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {state_a, mo_a, mc_a, dc_a, nudge_a, evt_a};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL dut_a @%0t: got st=%0d mo=%b mc=%b dc=%b nudge=%b evt=%b, expected st=%0d mo=%b mc=%b dc=%b nudge=%b evt=%b",
                 $time, act[6:5], act[4], act[3], act[2], act[1], act[0],
                 e[6:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      act = {state_b, mo_b, mc_b, dc_b, nudge_b, evt_b};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL dut_b @%0t: got st=%0d mo=%b mc=%b dc=%b nudge=%b evt=%b, expected st=%0d mo=%b mc=%b dc=%b nudge=%b evt=%b",
                 $time, act[6:5], act[4], act[3], act[2], act[1], act[0],
                 e[6:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // Stimulus and final report
  initial begin
    // Reset, then a nominal open/close cycle.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    idle(12);

    // Weight hold for 10 cycles from OPEN entry.
    step(1, 1, 0, 0);
    idle_until(2, -1);
    for (int k = 0; k < 10; k++) step(1, 0, 1, 0);
    idle(14);

    // Three obstruction reopens, fourth ignored in nudge mode.
    step(1, 1, 0, 0);
    obstruct_cycles(4);
    idle(15);

    // Weight on the last CLOSING cycle while nudging forces a reopen.
    step(1, 1, 0, 0);
    obstruct_cycles(3);
    idle_until(3, 1);
    step(1, 0, 1, 0);
    idle(20);

    // Reset mid-sequence with two reopens used, then a fresh full allowance.
    step(1, 1, 0, 0);
    obstruct_cycles(2);
    idle_until(2, -1);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    obstruct_cycles(4);
    idle(20);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0));
    end
    idle(20);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0/0", exp_q.size(), exp_q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
